// File: rtl/controller_fsm_br.sv
// Instruction-sequencing FSM for the simple RISC CPU: fetch, decode, ALU,
// load/store, moves, conditional branches, BL/BX/BLX and an illegal-opcode trap.
// Outputs are a pure decode of the state register (Moore).
module controller_fsm_br #(
    parameter int MEM_LAT = 1,   // fixed memory latency in cycles (1..15)
    parameter int USE_RDY = 0,   // 1: memory states end on mem_rdy
    parameter int SW      = 5    // state register width (>=5)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] opcode,
    input  logic [1:0] op,
    input  logic [2:0] cond,
    input  logic       Z,
    input  logic       N,
    input  logic       V,
    input  logic       mem_rdy,
    output logic [3:0] vsel,
    output logic [2:0] nsel,
    output logic       write,
    output logic       loada,
    output logic       loadb,
    output logic       loadc,
    output logic       loads,
    output logic       asel,
    output logic       bsel,
    output logic       load_pc,
    output logic       reset_pc,
    output logic       addr_sel,
    output logic       load_ir,
    output logic       load_addr,
    output logic [1:0] pc_sel,
    output logic [1:0] mem_cmd,
    output logic       halted,
    output logic       illegal
);

    typedef enum logic [SW-1:0] {
        RST, IF1, IF2, UPD_PC, DECODE,
        GET_A, GET_B, ALU, CMP, WB,
        ADDR, ADDR_LD, MEM_RD, LD_WB, ST_GB, ST_C, MEM_WR,
        MOV_IMM, MOVR1, MOVR2, MOVR3,
        BR_EVAL, BR_TAKE, BL_LINK, BL_JMP, BX_GET, BX_C, BX_JMP,
        HALT
    } state_e;

    localparam logic [1:0] MNONE  = 2'b00;
    localparam logic [1:0] MREAD  = 2'b01;
    localparam logic [1:0] MWRITE = 2'b11;

    state_e     state_q, state_d;
    logic [3:0] wait_q, wait_d;
    logic       illegal_q, illegal_d;
    logic       mem_done;
    logic       in_mem;
    logic       br_taken;

    // A memory state is finished either by the latency count or by the handshake.
    assign mem_done = (USE_RDY != 0) ? mem_rdy : (wait_q == 4'(MEM_LAT - 1));
    assign in_mem   = (state_q == IF1) || (state_q == MEM_RD) || (state_q == MEM_WR);

    // Branch condition decode; cond 101-111 are reserved and never taken.
    always_comb begin
        br_taken = 1'b0;
        case (cond)
            3'b000:  br_taken = 1'b1;
            3'b001:  br_taken = Z;
            3'b010:  br_taken = ~Z;
            3'b011:  br_taken = N ^ V;
            3'b100:  br_taken = (N ^ V) | Z;
            default: br_taken = 1'b0;
        endcase
    end

    // Next-state logic, sticky illegal flag and the memory wait counter.
    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        case (state_q)
            RST:     state_d = IF1;
            IF1:     if (mem_done) state_d = IF2;
            IF2:     state_d = UPD_PC;
            UPD_PC:  state_d = DECODE;
            DECODE: begin
                case (opcode)
                    3'b101, 3'b011, 3'b100: state_d = GET_A;
                    3'b001: state_d = BR_EVAL;
                    3'b111: state_d = HALT;
                    3'b110: begin
                        if (op == 2'b10)      state_d = MOV_IMM;
                        else if (op == 2'b00) state_d = MOVR1;
                        else begin
                            state_d   = HALT;
                            illegal_d = 1'b1;
                        end
                    end
                    3'b010: begin
                        if (op[1])            state_d = BL_LINK;  // BL (11) and BLX (10)
                        else if (op == 2'b00) state_d = BX_GET;
                        else begin
                            state_d   = HALT;
                            illegal_d = 1'b1;
                        end
                    end
                    default: begin
                        state_d   = HALT;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            // GET_A is shared: ALU ops read Rm next, LDR/STR form the address.
            GET_A:   state_d = (opcode == 3'b101) ? GET_B : ADDR;
            GET_B:   state_d = (op == 2'b01) ? CMP : ALU;
            ALU:     state_d = WB;
            WB:      state_d = IF1;
            CMP:     state_d = IF1;
            ADDR:    state_d = ADDR_LD;
            ADDR_LD: state_d = (opcode == 3'b100) ? ST_GB : MEM_RD;
            MEM_RD:  if (mem_done) state_d = LD_WB;
            LD_WB:   state_d = IF1;
            ST_GB:   state_d = ST_C;
            ST_C:    state_d = MEM_WR;
            MEM_WR:  if (mem_done) state_d = IF1;
            MOV_IMM: state_d = IF1;
            MOVR1:   state_d = MOVR2;
            MOVR2:   state_d = MOVR3;
            MOVR3:   state_d = IF1;
            BR_EVAL: state_d = br_taken ? BR_TAKE : IF1;
            BR_TAKE: state_d = IF1;
            BL_LINK: state_d = BL_JMP;
            // R7 is already linked here, so BLX R7 reads the fresh link value.
            BL_JMP: begin
                if (op == 2'b11)      state_d = BR_TAKE;
                else if (op == 2'b10) state_d = BX_GET;
                else                  state_d = IF1;
            end
            BX_GET:  state_d = BX_C;
            BX_C:    state_d = BX_JMP;
            BX_JMP:  state_d = IF1;
            HALT:    state_d = HALT;
            default: state_d = RST;   // unreachable encodings recover via RST
        endcase
        // Counter restarts on every entry and only advances while a memory state waits.
        wait_d = (in_mem && (state_d == state_q)) ? wait_q + 4'd1 : 4'd0;
    end

    // State, wait counter and illegal flag; reset aborts any instruction at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= RST;
            wait_q    <= 4'd0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            illegal_q <= illegal_d;
        end
    end

    assign illegal = illegal_q;

    // Moore output decode; anything not named in a state stays 0.
    always_comb begin
        vsel      = 4'b0000;
        nsel      = 3'b000;
        write     = 1'b0;
        loada     = 1'b0;
        loadb     = 1'b0;
        loadc     = 1'b0;
        loads     = 1'b0;
        asel      = 1'b0;
        bsel      = 1'b0;
        load_pc   = 1'b0;
        reset_pc  = 1'b0;
        addr_sel  = 1'b0;
        load_ir   = 1'b0;
        load_addr = 1'b0;
        pc_sel    = 2'b00;
        mem_cmd   = MNONE;
        halted    = 1'b0;
        case (state_q)
            RST:     begin reset_pc = 1'b1; load_pc = 1'b1; end
            IF1:     begin addr_sel = 1'b1; mem_cmd = MREAD; end
            IF2:     begin addr_sel = 1'b1; mem_cmd = MREAD; load_ir = 1'b1; end
            UPD_PC:  begin load_pc = 1'b1; pc_sel = 2'b00; end
            GET_A:   begin nsel = 3'b100; loada = 1'b1; end
            GET_B:   begin nsel = 3'b001; loadb = 1'b1; end
            ALU:     begin loadc = 1'b1; loads = 1'b1; end
            CMP:     loads = 1'b1;
            WB:      begin write = 1'b1; vsel = 4'b0001; nsel = 3'b010; end
            ADDR:    begin bsel = 1'b1; loadc = 1'b1; end
            ADDR_LD: load_addr = 1'b1;
            MEM_RD:  mem_cmd = MREAD;
            LD_WB:   begin mem_cmd = MREAD; write = 1'b1; vsel = 4'b1000; nsel = 3'b010; end
            ST_GB:   begin nsel = 3'b010; loadb = 1'b1; end
            ST_C:    begin asel = 1'b1; loadc = 1'b1; end
            MEM_WR:  mem_cmd = MWRITE;
            MOV_IMM: begin write = 1'b1; vsel = 4'b0100; nsel = 3'b100; end
            MOVR1:   begin nsel = 3'b001; loadb = 1'b1; end
            MOVR2:   begin asel = 1'b1; loadc = 1'b1; end
            MOVR3:   begin write = 1'b1; vsel = 4'b0001; nsel = 3'b010; end
            BR_TAKE: begin load_pc = 1'b1; pc_sel = 2'b01; end
            BL_LINK: begin write = 1'b1; vsel = 4'b0010; nsel = 3'b100; end
            BX_GET:  begin nsel = 3'b010; loadb = 1'b1; end
            BX_C:    begin asel = 1'b1; loadc = 1'b1; end
            BX_JMP:  begin load_pc = 1'b1; pc_sel = 2'b10; end
            HALT:    halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_controller_fsm_br.sv
// Directed bench for controller_fsm_br. Four instances: 0 MEM_LAT=1, 1 MEM_LAT=3,
// 2 MEM_LAT=4, 3 USE_RDY=1. Each cycle the output set is packed into one word
// and compared with a hand-written pattern for the state expected there.
module tb_controller_fsm_br;
    localparam int NDUT = 4;

    logic            clk = 1'b0;
    logic [NDUT-1:0] rst = '1;
    logic [NDUT-1:0] mem_rdy = '0;
    logic [2:0]      opcode = 3'b000;
    logic [1:0]      op = 2'b00;
    logic [2:0]      cond = 3'b000;
    logic            Z = 1'b0, N = 1'b0, V = 1'b0;

    logic [3:0] vsel     [NDUT];
    logic [2:0] nsel     [NDUT];
    logic [1:0] pc_sel   [NDUT];
    logic [1:0] mem_cmd  [NDUT];
    logic write [NDUT], loada [NDUT], loadb [NDUT], loadc [NDUT], loads [NDUT];
    logic asel [NDUT], bsel [NDUT], load_pc [NDUT], reset_pc [NDUT], addr_sel [NDUT];
    logic load_ir [NDUT], load_addr [NDUT], halted [NDUT], illegal [NDUT];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int L = (g == 1) ? 3 : (g == 2) ? 4 : 1;
        localparam int R = (g == 3) ? 1 : 0;
        controller_fsm_br #(.MEM_LAT(L), .USE_RDY(R), .SW(5)) u_dut (
            .clk(clk), .reset(rst[g]), .opcode(opcode), .op(op), .cond(cond),
            .Z(Z), .N(N), .V(V), .mem_rdy(mem_rdy[g]),
            .vsel(vsel[g]), .nsel(nsel[g]), .write(write[g]), .loada(loada[g]),
            .loadb(loadb[g]), .loadc(loadc[g]), .loads(loads[g]), .asel(asel[g]),
            .bsel(bsel[g]), .load_pc(load_pc[g]), .reset_pc(reset_pc[g]),
            .addr_sel(addr_sel[g]), .load_ir(load_ir[g]), .load_addr(load_addr[g]),
            .pc_sel(pc_sel[g]), .mem_cmd(mem_cmd[g]), .halted(halted[g]),
            .illegal(illegal[g])
        );
    end

    // Pattern layout: {vsel, nsel, {write,loada,loadb,loadc,loads,asel,bsel},
    //   {load_pc,reset_pc,addr_sel,load_ir,load_addr}, pc_sel, mem_cmd, {halted,illegal}}
    localparam logic [24:0] E_RST   = {4'b0000, 3'b000, 7'b0000000, 5'b11000, 2'b00, 2'b00, 2'b00};
    localparam logic [24:0] E_IF1   = {4'b0000, 3'b000, 7'b0000000, 5'b00100, 2'b00, 2'b01, 2'b00};
    localparam logic [24:0] E_IF2   = {4'b0000, 3'b000, 7'b0000000, 5'b00110, 2'b00, 2'b01, 2'b00};
    localparam logic [24:0] E_UPD   = {4'b0000, 3'b000, 7'b0000000, 5'b10000, 2'b00, 2'b00, 2'b00};
    localparam logic [24:0] E_IDLE  = 25'd0;
    localparam logic [24:0] E_GETA  = {4'b0000, 3'b100, 7'b0100000, 5'b00000, 2'b00, 2'b00, 2'b00};
    localparam logic [24:0] E_RDB_M = {4'b0000, 3'b001, 7'b0010000, 5'b00000, 2'b00, 2'b00, 2'b00};
    localparam logic [24:0] E_ALU   = {4'b0000, 3'b000, 7'b0001100, 5'b00000, 2'b00, 2'b00, 2'b00};
    localparam logic [24:0] E_CMP   = {4'b0000, 3'b000, 7'b0000100, 5'b00000, 2'b00, 2'b00, 2'b00};
    localparam logic [24:0] E_WB    = {4'b0001, 3'b010, 7'b1000000, 5'b00000, 2'b00, 2'b00, 2'b00};
    localparam logic [24:0] E_MOVI  = {4'b0100, 3'b100, 7'b1000000, 5'b00000, 2'b00, 2'b00, 2'b00};
    localparam logic [24:0] E_ASELC = {4'b0000, 3'b000, 7'b0001010, 5'b00000, 2'b00, 2'b00, 2'b00};
    localparam logic [24:0] E_ADDR  = {4'b0000, 3'b000, 7'b0001001, 5'b00000, 2'b00, 2'b00, 2'b00};
    localparam logic [24:0] E_ADDLD = {4'b0000, 3'b000, 7'b0000000, 5'b00001, 2'b00, 2'b00, 2'b00};
    localparam logic [24:0] E_MEMRD = {4'b0000, 3'b000, 7'b0000000, 5'b00000, 2'b00, 2'b01, 2'b00};
    localparam logic [24:0] E_LDWB  = {4'b1000, 3'b010, 7'b1000000, 5'b00000, 2'b00, 2'b01, 2'b00};
    localparam logic [24:0] E_RDB_D = {4'b0000, 3'b010, 7'b0010000, 5'b00000, 2'b00, 2'b00, 2'b00};
    localparam logic [24:0] E_MEMWR = {4'b0000, 3'b000, 7'b0000000, 5'b00000, 2'b00, 2'b11, 2'b00};
    localparam logic [24:0] E_BRT   = {4'b0000, 3'b000, 7'b0000000, 5'b10000, 2'b01, 2'b00, 2'b00};
    localparam logic [24:0] E_BLL   = {4'b0010, 3'b100, 7'b1000000, 5'b00000, 2'b00, 2'b00, 2'b00};
    localparam logic [24:0] E_BXJ   = {4'b0000, 3'b000, 7'b0000000, 5'b10000, 2'b10, 2'b00, 2'b00};
    localparam logic [24:0] E_HALT  = {4'b0000, 3'b000, 7'b0000000, 5'b00000, 2'b00, 2'b00, 2'b10};
    localparam logic [24:0] E_HALTI = {4'b0000, 3'b000, 7'b0000000, 5'b00000, 2'b00, 2'b00, 2'b11};

    int          n_cmp = 0;
    int          n_err = 0;
    logic [24:0] exp_q [$];
    logic [6:0]  br_tab [10];   // {cond, Z, N, V, taken}
    int          n;

    function automatic logic [24:0] sig(input int d);
        return {vsel[d], nsel[d], write[d], loada[d], loadb[d], loadc[d], loads[d],
                asel[d], bsel[d], load_pc[d], reset_pc[d], addr_sel[d], load_ir[d],
                load_addr[d], pc_sel[d], mem_cmd[d], halted[d], illegal[d]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One check per cycle against exp_q, starting on the next clock.
    task automatic run_seq(input int d, input string tag);
        foreach (exp_q[i]) begin
            tick();
            chk($sformatf("%s[%0d]", tag, i), 32'(sig(d)), 32'(exp_q[i]));
        end
    endtask

    // Counts consecutive cycles showing pattern p (bounded by maxc).
    task automatic count_pat(input int d, input logic [24:0] p, input int maxc, output int cnt);
        cnt = 0;
        tick();
        while (sig(d) == p && cnt < maxc) begin
            cnt++;
            tick();
        end
    endtask

    task automatic release_rst(input int d);
        rst[d] = 1'b0;
        tick();
        chk($sformatf("if1_after_rst%0d", d), 32'(sig(d)), 32'(E_IF1));
    endtask

    task automatic set_ins(input logic [2:0] oc, input logic [1:0] o);
        opcode = oc;
        op     = o;
    endtask

    initial begin
        br_tab = '{7'b000_000_1, 7'b001_100_1, 7'b010_100_0, 7'b010_000_1, 7'b011_010_1,
                   7'b011_011_0, 7'b100_100_1, 7'b100_000_0, 7'b101_110_0, 7'b111_100_0};
        tick();
        tick();
        chk("reset_state", 32'(sig(0)), 32'(E_RST));
        release_rst(0);

        // MOV R0,#5 then ADD R1,R0,R0
        set_ins(3'b110, 2'b10);
        exp_q = '{E_IF2, E_UPD, E_IDLE, E_MOVI, E_IF1};
        run_seq(0, "mov_imm");
        set_ins(3'b101, 2'b00);
        exp_q = '{E_IF2, E_UPD, E_IDLE, E_GETA, E_RDB_M, E_ALU, E_WB, E_IF1};
        run_seq(0, "add");
        set_ins(3'b110, 2'b10);
        tick();
        chk("mov_ir_cycle", 32'(sig(0)), 32'(E_IF2));
        n = 0;
        do begin
            tick();
            n++;
        end while (sig(0) != E_IF1 && n < 20);
        chk("mov_ir_to_if1", 32'(n), 32'd4);

        // CMP followed by every branch condition in the table
        foreach (br_tab[i]) begin
            set_ins(3'b101, 2'b01);
            exp_q = '{E_IF2, E_UPD, E_IDLE, E_GETA, E_RDB_M, E_CMP, E_IF1};
            run_seq(0, $sformatf("cmp%0d", i));
            set_ins(3'b001, 2'b00);
            {cond, Z, N, V} = br_tab[i][6:1];
            if (br_tab[i][0]) exp_q = '{E_IF2, E_UPD, E_IDLE, E_IDLE, E_BRT, E_IF1};
            else              exp_q = '{E_IF2, E_UPD, E_IDLE, E_IDLE, E_IF1};
            run_seq(0, $sformatf("br_c%0d_%0d", br_tab[i][6:4], i));
        end

        // BL, BX, BLX
        set_ins(3'b010, 2'b11);
        exp_q = '{E_IF2, E_UPD, E_IDLE, E_BLL, E_IDLE, E_BRT, E_IF1};
        run_seq(0, "bl");
        set_ins(3'b010, 2'b00);
        exp_q = '{E_IF2, E_UPD, E_IDLE, E_RDB_D, E_ASELC, E_BXJ, E_IF1};
        run_seq(0, "bx");
        set_ins(3'b010, 2'b10);
        exp_q = '{E_IF2, E_UPD, E_IDLE, E_BLL, E_IDLE, E_RDB_D, E_ASELC, E_BXJ, E_IF1};
        run_seq(0, "blx");

        // LDR, STR, MOV Rd,Rm at single-cycle latency
        set_ins(3'b011, 2'b00);
        exp_q = '{E_IF2, E_UPD, E_IDLE, E_GETA, E_ADDR, E_ADDLD, E_MEMRD, E_LDWB, E_IF1};
        run_seq(0, "ldr");
        set_ins(3'b100, 2'b00);
        exp_q = '{E_IF2, E_UPD, E_IDLE, E_GETA, E_ADDR, E_ADDLD, E_RDB_D, E_ASELC, E_MEMWR, E_IF1};
        run_seq(0, "str");
        set_ins(3'b110, 2'b00);
        exp_q = '{E_IF2, E_UPD, E_IDLE, E_RDB_M, E_ASELC, E_WB, E_IF1};
        run_seq(0, "mov_reg");

        // Legal HALT, then reset
        set_ins(3'b111, 2'b00);
        exp_q = '{E_IF2, E_UPD, E_IDLE, E_HALT, E_HALT, E_HALT};
        run_seq(0, "halt");
        rst[0] = 1'b1;
        #1;
        chk("halt_reset", 32'(sig(0)), 32'(E_RST));
        tick();
        release_rst(0);

        // Undefined opcode 000: trap and hold, reset clears halted and illegal
        set_ins(3'b000, 2'b00);
        exp_q = '{E_IF2, E_UPD, E_IDLE, E_HALTI};
        run_seq(0, "illegal");
        count_pat(0, E_HALTI, 20, n);
        chk("illegal_hold20", 32'(n), 32'd20);
        rst[0] = 1'b1;
        #1;
        chk("illegal_reset", 32'(sig(0)), 32'(E_RST));
        tick();
        release_rst(0);
        set_ins(3'b010, 2'b01);
        exp_q = '{E_IF2, E_UPD, E_IDLE, E_HALTI};
        run_seq(0, "illegal_010_01");
        rst[0] = 1'b1;

        // MEM_LAT=3: STR aborted by reset in the second MEM_WR cycle
        set_ins(3'b100, 2'b00);
        rst[1] = 1'b0;
        exp_q = '{E_IF1, E_IF1, E_IF1, E_IF2, E_UPD, E_IDLE, E_GETA, E_ADDR, E_ADDLD,
                  E_RDB_D, E_ASELC, E_MEMWR, E_MEMWR};
        run_seq(1, "str_lat3");
        rst[1] = 1'b1;
        #1;
        chk("memwr_abort", 32'(sig(1)), 32'(E_RST));
        tick();
        chk("memwr_abort_hold", 32'(sig(1)), 32'(E_RST));
        release_rst(1);

        // MEM_LAT=4: IF1 holds MREAD for four cycles
        rst[2] = 1'b0;
        count_pat(2, E_IF1, 30, n);
        chk("if1_lat4", 32'(n), 32'd4);
        chk("if2_after_lat4", 32'(sig(2)), 32'(E_IF2));

        // USE_RDY=1: mem_rdy raised in the sixth IF1 cycle
        rst[3] = 1'b0;
        n = 0;
        tick();
        for (int i = 0; i < 12; i++) begin
            if (sig(3) != E_IF1) break;
            n++;
            if (n == 6) mem_rdy[3] = 1'b1;
            tick();
        end
        mem_rdy[3] = 1'b0;
        chk("if1_rdy", 32'(n), 32'd6);
        chk("if2_after_rdy", 32'(sig(3)), 32'(E_IF2));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
